// File: rtl/wb_regfile_scoreboard_pkg.sv
// Constants and types shared by the ID stage, the WB stage and the register file scoreboard.
package wb_regfile_scoreboard_pkg;

  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int DATA_W   = 32;
  localparam int PEND_W   = 2;

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_scoreboard_sb_pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one architectural register.
module sb_pend_counter
  import wb_regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              zero,
  output logic              max
);

  assign zero = (cnt == PEND_ZERO);
  assign max  = (cnt == PEND_MAX);

  // Count update; simultaneous inc and dec cancel, ends of range hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= PEND_ZERO;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (!max) cnt <= cnt + PEND_ONE;
          else      cnt <= cnt;
        end
        2'b01: begin
          if (!zero) cnt <= cnt - PEND_ONE;
          else       cnt <= cnt;
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-through bypassed read ports and a
// per-register pending-write scoreboard that stalls ID on RAW hazards or counter overflow.
module wb_regfile_scoreboard
  import wb_regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic [ADDR_W-1:0] wb_dest_in,
  input  logic [DATA_W-1:0] wb_result_in,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic              src1_used,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic              src2_used,
  output logic [DATA_W-1:0] src1_val,
  output logic [DATA_W-1:0] src2_val,
  input  logic              issue_en,
  input  logic              issue_wb,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              busy,
  output logic              sb_err
);

  logic [DATA_W-1:0]               regs [NUM_REGS];
  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_REGS-1:0]             pend_zero;
  logic [NUM_REGS-1:0]             pend_max;
  logic [NUM_REGS-1:0]             ret;
  logic [NUM_REGS-1:0]             inc;
  logic                            raw1;
  logic                            raw2;
  logic                            full;
  logic                            acc;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
    assign ret[i] = wb_en_in & (wb_dest_in == ADDR_W'(i)) & ~pend_zero[i];
    assign inc[i] = acc & issue_wb & (issue_dest == ADDR_W'(i));

    sb_pend_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .dec  (ret[i]),
      .cnt  (pend[i]),
      .zero (pend_zero[i]),
      .max  (pend_max[i])
    );
  end

  // The last outstanding write retiring this cycle is forwarded, so it is not a hazard.
  assign raw1  = src1_used & ~pend_zero[src1_addr]
               & ~((pend[src1_addr] == PEND_ONE) & ret[src1_addr]);
  assign raw2  = src2_used & ~pend_zero[src2_addr]
               & ~((pend[src2_addr] == PEND_ONE) & ret[src2_addr]);
  assign full  = issue_wb & pend_max[issue_dest] & ~ret[issue_dest];
  assign stall = ~rst & issue_en & (raw1 | raw2 | full);
  assign acc   = issue_en & ~stall;
  assign busy  = |(~pend_zero);

  // Register storage; a write lands even when it is unmatched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= {DATA_W{1'b0}};
    end else if (wb_en_in) begin
      regs[wb_dest_in] <= wb_result_in;
    end else begin
      regs[wb_dest_in] <= regs[wb_dest_in];
    end
  end

  // Sticky flag for a writeback with nothing outstanding on its destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (wb_en_in && pend_zero[wb_dest_in]) begin
      sb_err <= 1'b1;
    end else begin
      sb_err <= sb_err;
    end
  end

  // Read port 1 with write-through bypass.
  always_comb begin
    src1_val = {DATA_W{1'b0}};
    if (rst) begin
      src1_val = {DATA_W{1'b0}};
    end else if (wb_en_in && (src1_addr == wb_dest_in)) begin
      src1_val = wb_result_in;
    end else begin
      src1_val = regs[src1_addr];
    end
  end

  // Read port 2 with write-through bypass.
  always_comb begin
    src2_val = {DATA_W{1'b0}};
    if (rst) begin
      src2_val = {DATA_W{1'b0}};
    end else if (wb_en_in && (src2_addr == wb_dest_in)) begin
      src2_val = wb_result_in;
    end else begin
      src2_val = regs[src2_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: a rule-level model checked every negedge,
// plus hand-computed literal expectations for each scenario.
`timescale 1ns/100ps
module tb_wb_regfile_scoreboard;

  localparam int PMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in;
  logic [3:0]  wb_dest_in;
  logic [31:0] wb_result_in;
  logic [3:0]  src1_addr, src2_addr, issue_dest;
  logic        src1_used, src2_used, issue_en, issue_wb;
  logic [31:0] src1_val, src2_val;
  logic        stall, busy, sb_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mreg  [16];
  int          mpend [16];
  bit          merr;

  wb_regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .wb_dest_in(wb_dest_in), .wb_result_in(wb_result_in),
    .src1_addr(src1_addr), .src1_used(src1_used),
    .src2_addr(src2_addr), .src2_used(src2_used),
    .src1_val(src1_val), .src2_val(src2_val),
    .issue_en(issue_en), .issue_wb(issue_wb), .issue_dest(issue_dest),
    .stall(stall), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ret(int r);
    return wb_en_in && int'(wb_dest_in) == r && mpend[r] > 0;
  endfunction

  function automatic bit m_raw(int a, bit used);
    return used && mpend[a] > 0 && !(mpend[a] == 1 && m_ret(a));
  endfunction

  function automatic bit m_stall();
    if (rst) return 1'b0;
    return issue_en && (m_raw(int'(src1_addr), src1_used) || m_raw(int'(src2_addr), src2_used)
           || (issue_wb && mpend[issue_dest] == PMAX && !m_ret(int'(issue_dest))));
  endfunction

  function automatic logic [31:0] m_src(logic [3:0] a);
    if (rst) return 32'h0;
    if (wb_en_in && a == wb_dest_in) return wb_result_in;
    return mreg[a];
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < 16; i++) if (mpend[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model state update
  always @(posedge clk or posedge rst) begin : model
    int np [16];
    bit acc, r;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mreg[i]  <= 32'h0;
        mpend[i] <= 0;
      end
      merr <= 1'b0;
    end else begin
      acc = issue_en && !m_stall();
      r   = m_ret(int'(wb_dest_in));
      for (int i = 0; i < 16; i++) np[i] = mpend[i];
      if (wb_en_in) begin
        if (mpend[wb_dest_in] == 0) merr <= 1'b1;
        mreg[wb_dest_in] <= wb_result_in;
      end
      if (r) np[wb_dest_in] = np[wb_dest_in] - 1;
      if (acc && issue_wb) np[issue_dest] = np[issue_dest] + 1;
      for (int i = 0; i < 16; i++) mpend[i] <= np[i];
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("src1_val", src1_val, m_src(src1_addr));
    check("src2_val", src2_val, m_src(src2_addr));
    check("stall", {31'b0, stall}, {31'b0, m_stall()});
    check("busy", {31'b0, busy}, {31'b0, m_busy()});
    check("sb_err", {31'b0, sb_err}, {31'b0, merr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en_in = 1'b0; wb_dest_in = 4'd0; wb_result_in = 32'h0;
    src1_addr = 4'd0; src1_used = 1'b0; src2_addr = 4'd0; src2_used = 1'b0;
    issue_en = 1'b0; issue_wb = 1'b0; issue_dest = 4'd0;
  endtask

  task automatic issue(input logic [3:0] d);
    issue_en = 1'b1; issue_wb = 1'b1; issue_dest = d;
  endtask

  task automatic wb(input logic [3:0] d, input logic [31:0] v);
    wb_en_in = 1'b1; wb_dest_in = d; wb_result_in = v;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    #5;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_sb_err", {31'b0, sb_err}, 32'd0);
    tick();

    // Load r5 = 0x11 through a matched issue/writeback pair
    idle(); issue(4'd5); tick();
    idle(); #5; check("busy_after_issue", {31'b0, busy}, 32'd1);
    wb(4'd5, 32'h11); tick();

    // Bypass: writeback and read of r5 in the same cycle
    idle(); issue(4'd5); tick();
    idle(); src1_addr = 4'd5; #5;
    check("r5_stored", src1_val, 32'h11);
    wb(4'd5, 32'hDEADBEEF); issue_en = 1'b1; src1_used = 1'b1; #1;
    check("bypass_val", src1_val, 32'hDEADBEEF);
    check("bypass_no_stall", {31'b0, stall}, 32'd0);
    tick();
    idle(); src1_addr = 4'd5; #5;
    check("stored_val", src1_val, 32'hDEADBEEF);
    check("busy_cleared", {31'b0, busy}, 32'd0);
    tick();

    // RAW stall on src2 until the writeback to r2 arrives
    idle(); issue(4'd2); tick();
    idle(); issue_en = 1'b1; src2_addr = 4'd2; src2_used = 1'b1; #5;
    check("raw_stall_1", {31'b0, stall}, 32'd1);
    tick(); #5;
    check("raw_stall_2", {31'b0, stall}, 32'd1);
    tick();
    wb(4'd2, 32'hCAFE0002); #5;
    check("raw_wb_no_stall", {31'b0, stall}, 32'd0);
    check("raw_wb_val", src2_val, 32'hCAFE0002);
    tick();

    // Unused source never stalls
    idle(); issue(4'd2); tick();
    idle(); issue_en = 1'b1; src2_addr = 4'd2; src2_used = 1'b0; #5;
    check("unused_no_stall", {31'b0, stall}, 32'd0);
    tick();
    idle(); wb(4'd2, 32'h2222); tick();

    // Saturation of r7
    idle(); issue(4'd7); tick(); tick(); tick();
    #5; check("sat_stall", {31'b0, stall}, 32'd1);
    tick();
    wb(4'd7, 32'h77); #5;
    check("sat_wb_accept", {31'b0, stall}, 32'd0);
    tick();
    idle(); issue(4'd7); #5;
    check("sat_still_full", {31'b0, stall}, 32'd1);
    tick();
    idle(); wb(4'd7, 32'h71); tick(); wb(4'd7, 32'h72); tick(); wb(4'd7, 32'h73); tick();
    idle(); #5;
    check("sat_drained", {31'b0, busy}, 32'd0);
    check("no_err_yet", {31'b0, sb_err}, 32'd0);
    tick();

    // Unmatched writeback to r9
    idle(); wb(4'd9, 32'h99); tick();
    idle(); src1_addr = 4'd9; #5;
    check("err_set", {31'b0, sb_err}, 32'd1);
    check("err_write_lands", src1_val, 32'h99);
    tick(); tick(); #5;
    check("err_sticky", {31'b0, sb_err}, 32'd1);
    tick();

    // Issue and writeback to the same idle register
    idle(); issue(4'd10); wb(4'd10, 32'hA0); tick();
    idle(); #5;
    check("same_cycle_busy", {31'b0, busy}, 32'd1);
    tick();
    wb(4'd10, 32'hA1); tick();

    // Reset mid-cycle with r3 holding two pending writes
    idle(); issue(4'd3); tick(); tick();
    idle(); rst = 1'b1; #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_sb_err", {31'b0, sb_err}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      src1_addr = 4'(a); #0.2;
      check("midrst_src1", src1_val, 32'h0);
    end
    tick();
    rst = 1'b0; idle(); wb(4'd3, 32'h33); tick();
    idle(); #5;
    check("post_rst_err", {31'b0, sb_err}, 32'd1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
Receiving end of the writeback interface. It consumes the WB stage's write-enable, destination and result, and holds the architectural register file. It provides two bypassed read ports to the ID stage. A per-register pending-write scoreboard lets ID detect RAW hazards on instructions still in flight, and stall issue until they clear.

Parameters:
NUM_REGS, 16, number of architectural registers
ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W
DATA_W, 32, register data width
PEND_W, 2, per-register in-flight counter width; max in-flight writes per register = 2**PEND_W-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
wb_en_in  in  1  writeback enable from WB stage
wb_dest_in  in  ADDR_W  writeback destination register
wb_result_in  in  DATA_W  writeback data (ALU or memory result, already muxed)
src1_addr  in  ADDR_W  ID read port 1 address
src1_used  in  1  instruction really reads src1
src2_addr  in  ADDR_W  ID read port 2 address
src2_used  in  1  instruction really reads src2
src1_val  out  DATA_W  read data port 1
src2_val  out  DATA_W  read data port 2
issue_en  in  1  ID wants to issue an instruction this cycle
issue_wb  in  1  issuing instruction will write back
issue_dest  in  ADDR_W  its destination register
stall  out  1  issue refused this cycle; ID must hold
busy  out  1  any pending counter non-zero
sb_err  out  1  sticky: writeback to a register with zero pending

Behaviour:
- Reset (async, rst=1): all registers = 0, all pending counters = 0, sb_err = 0. Outputs while in reset: src*_val = 0, busy = 0, stall = 0.
- Register write: on posedge when wb_en_in=1, reg[wb_dest_in] <= wb_result_in. A write happens even when sb_err fires.
- Reads are combinational. Write-through bypass: if wb_en_in=1 and srcN_addr==wb_dest_in, then srcN_val = wb_result_in; otherwise srcN_val = reg[srcN_addr].
- Per-register retire: ret[i] = wb_en_in & wb_dest_in==i & pend[i]!=0.
- Per-register RAW: rawN = srcN_used & pend[srcN_addr]!=0 & !(pend[srcN_addr]==1 & ret[srcN_addr]). The last write retiring this cycle is covered by the bypass, so it is not a hazard.
- Full: full = issue_wb & pend[issue_dest]==2**PEND_W-1 & !ret[issue_dest].
- Stall: stall = issue_en & (raw1 | raw2 | full). Combinational; no added latency.
- Accepted issue: acc = issue_en & !stall. inc[i] = acc & issue_wb & issue_dest==i.
- Counter update each posedge: pend[i] <= pend[i] + inc[i] - ret[i]. Simultaneous inc and ret on the same register leaves it unchanged. Counters never wrap: full blocks increment at max, and ret blocks decrement at 0.
- sb_err: set on a posedge where wb_en_in=1 and pend[wb_dest_in]==0. Cleared only by rst.
- busy = OR over pend[i]!=0. It is registered-state derived, so it updates the cycle after the last retire.
- Issue and writeback to the same register in one cycle with pend==0: the counter goes to 1, and sb_err is set because the writeback was unmatched.
- Reset mid-operation: all in-flight tracking is discarded immediately; the first post-reset writebacks set sb_err unless the pipeline is also flushed.
- Latency: a write at edge T is visible via bypass during cycle T-1→T, and from storage from T onward.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_REGS, PEND_W constants, and a reg-index typedef, all shared with the ID and WB stages.
- One sub-module, sb_pend_counter: a saturating up/down counter with inputs inc, dec and outputs cnt, zero, max. It is instanced NUM_REGS times in a generate loop.
- Storage array and bypass muxes stay in the top module.

Test Plan:
- Reset state: assert rst mid-cycle with pend[3]=2 → immediately busy=0, src1_val=0 for all addresses, sb_err=0.
- Bypass: reg5=0x11 and no pending writes; issue writing r5, then wb_en_in=1, wb_dest_in=5, wb_result_in=0xDEADBEEF with src1_addr=5 in the same cycle → src1_val=0xDEADBEEF, stall=0; the next cycle reads 0xDEADBEEF from storage.
- RAW stall: issue writing r2 accepted, next cycle issue_en with src2_addr=2, src2_used=1 → stall=1 until the writeback to r2 arrives; in the WB cycle stall=0 and src2_val=the WB data.
- Unused source: same as the RAW stall case but src2_used=0 → stall=0.
- Saturation (PEND_W=2): three accepted issues to r7, fourth issue_en writing r7 → stall=1 and pend stays 3; fourth issue coinciding with a WB to r7 → accepted, pend stays 3.
- Error flag: wb_en_in=1 to r9 with pend[9]=0 → sb_err=1 after the edge, reg9 is written, and sb_err stays 1 until rst.
